// File: rtl/pkt_to_msg_queue.sv
// pkt_to_msg_queue: packet FIFO re-serialised into a first/last-marked flit stream.
// Define PKT2MSG_FORMAT_CHECK_EN to drop packets whose flit 0 is not a head and raise sticky err_o.
module pkt_to_msg_queue #(
  parameter int FLIT_WIDTH        = 32,
  parameter int MAX_PACKET_LENGTH = 4,
  parameter int DEPTH             = 4,
  parameter int FLIT_TYPE_LSB     = 0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  r_pkt_to_msg_i,
  output logic                                  g_pkt_to_msg_o,
  input  logic [MAX_PACKET_LENGTH*FLIT_WIDTH-1:0] in_link_i,
  output logic                                  msg_valid_o,
  input  logic                                  msg_ready_i,
  output logic [FLIT_WIDTH-1:0]                 msg_data_o,
  output logic                                  msg_first_o,
  output logic                                  msg_last_o,
  output logic [$clog2(DEPTH+1)-1:0]            occupancy_o,
  output logic                                  err_o
);
  localparam int OW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int IW = MAX_PACKET_LENGTH > 1 ? $clog2(MAX_PACKET_LENGTH) : 1;
  localparam logic [OW-1:0] FULL = OW'(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(MAX_PACKET_LENGTH - 1);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state;
  logic [MAX_PACKET_LENGTH*FLIT_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [IW-1:0] idx;
  logic [OW-1:0] occ_n;
  logic [1:0] ftype;
  logic push, xfer, pop;
  assign g_pkt_to_msg_o = r_pkt_to_msg_i && (occupancy_o < FULL);
  assign msg_valid_o = state == STREAM;
  assign msg_data_o = mem[rd_ptr][idx*FLIT_WIDTH +: FLIT_WIDTH];
  assign ftype = msg_data_o[FLIT_TYPE_LSB +: 2];
  assign msg_first_o = msg_valid_o && idx == '0;
  // TAIL and HEAD_TAIL both have the upper type bit set; the length cap ends tail-less packets
  assign msg_last_o = msg_valid_o && (ftype[1] || idx == LAST_IDX);
  assign xfer = msg_valid_o && msg_ready_i;
  assign pop = xfer && msg_last_o;
  assign occ_n = occupancy_o + OW'(push) - OW'(pop);
`ifdef PKT2MSG_FORMAT_CHECK_EN
  logic [1:0] htype;
  assign htype = in_link_i[FLIT_TYPE_LSB +: 2];
  assign push = g_pkt_to_msg_o && htype[1] == htype[0];
  always_ff @(posedge clk)
    if (rst) err_o <= 1'b0;
    else if (g_pkt_to_msg_o && htype[1] != htype[0]) err_o <= 1'b1;
`else
  assign push = g_pkt_to_msg_o;
  assign err_o = 1'b0;
`endif
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= in_link_i;
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      idx         <= '0;
      occupancy_o <= '0;
      state       <= IDLE;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (xfer) idx <= msg_last_o ? '0 : idx + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      occupancy_o <= occ_n;
      state <= occ_n != '0 ? STREAM : IDLE;
    end
endmodule

// File: tb/tb_pkt_to_msg_queue.sv
// tb_pkt_to_msg_queue: directed checks of grant, ordering, first/last marking and format check.
module tb_pkt_to_msg_queue;
  localparam logic [1:0] H = 2'b00, B = 2'b01, T = 2'b10, HT = 2'b11;
  logic clk = 0, rst = 1, req = 0, ready = 0;
  logic [127:0] link = '0;
  logic g, valid, first, last, err;
  logic [31:0] data;
  logic [2:0] occ;
  int pass_cnt = 0, tot = 0;
  pkt_to_msg_queue dut (
    .clk(clk), .rst(rst), .r_pkt_to_msg_i(req), .g_pkt_to_msg_o(g), .in_link_i(link),
    .msg_valid_o(valid), .msg_ready_i(ready), .msg_data_o(data), .msg_first_o(first),
    .msg_last_o(last), .occupancy_o(occ), .err_o(err)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] fl(input logic [7:0] id, input logic [1:0] t);
    return {22'h0, id, t};
  endfunction
  function automatic logic [127:0] pk(input logic [7:0] id, input logic [1:0] t0, t1, t2, t3);
    return {fl(id + 8'd3, t3), fl(id + 8'd2, t2), fl(id + 8'd1, t1), fl(id, t0)};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tot++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    #1;
  endtask
  task automatic chk_flit(input string tag, input logic [31:0] d, input logic f, input logic l);
    chk({tag, ".valid"}, 32'(valid), 1);
    chk({tag, ".data"}, data, d);
    chk({tag, ".first"}, 32'(first), 32'(f));
    chk({tag, ".last"}, 32'(last), 32'(l));
  endtask
  task automatic push(input logic [127:0] p);
    req = 1; link = p; settle();
    chk("push.grant", 32'(g), 1);
    step();
    req = 0; settle();
  endtask
  initial begin
    step(); step();
    rst = 0; settle();
    chk("rst.valid", 32'(valid), 0);
    chk("rst.occ", 32'(occ), 0);
    chk("rst.err", 32'(err), 0);
    chk("rst.grant", 32'(g), 0);
    // basic HEAD,BODY,TAIL packet
    ready = 1;
    push(pk(8'h10, H, B, T, B));
    chk("p1.occ", 32'(occ), 1);
    chk_flit("p1.f0", fl(8'h10, H), 1, 0);
    step(); chk_flit("p1.f1", fl(8'h11, B), 0, 0);
    step(); chk_flit("p1.f2", fl(8'h12, T), 0, 1);
    step(); chk("p1.empty", 32'(valid), 0);
    chk("p1.occ0", 32'(occ), 0);
    // single-flit packet
    push(pk(8'h20, HT, B, B, B));
    chk_flit("ht", fl(8'h20, HT), 1, 1);
    step(); chk("ht.empty", 32'(valid), 0);
    // fill, block the fifth request, then drain across the pointer wrap
    ready = 0;
    push(pk(8'h30, H, T, B, B));
    push(pk(8'h40, H, T, B, B));
    push(pk(8'h50, H, T, B, B));
    push(pk(8'h60, H, T, B, B));
    req = 1; link = pk(8'h70, H, T, B, B); settle();
    chk("full.grant", 32'(g), 0);
    chk("full.occ", 32'(occ), 4);
    ready = 1; settle();
    chk_flit("a0", fl(8'h30, H), 1, 0);
    step(); chk("lastpop.grant", 32'(g), 0);
    chk_flit("a1", fl(8'h31, T), 0, 1);
    step(); chk("afterpop.grant", 32'(g), 1);
    chk("afterpop.occ", 32'(occ), 3);
    chk_flit("b0", fl(8'h40, H), 1, 0);
    step(); req = 0; settle();
    chk("refill.occ", 32'(occ), 4);
    chk_flit("b1", fl(8'h41, T), 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(); chk_flit("wrap.f0", fl(8'h50 + 8'(16 * i), H), 1, 0);
      step(); chk_flit("wrap.f1", fl(8'h51 + 8'(16 * i), T), 0, 1);
    end
    step(); chk("wrap.empty", 32'(valid), 0);
    // no tail: length cap ends the packet
    push(pk(8'h80, H, B, B, B));
    for (int i = 0; i < 4; i++) begin
      chk_flit("cap", fl(8'h80 + 8'(i), i == 0 ? H : B), i == 0, i == 3);
      step();
    end
    chk("cap.empty", 32'(valid), 0);
    // push coinciding with last-flit pop at occupancy 2
    ready = 0;
    push(pk(8'h90, H, T, B, B));
    push(pk(8'hA0, H, T, B, B));
    ready = 1; settle();
    chk_flit("x0", fl(8'h90, H), 1, 0);
    step();
    req = 1; link = pk(8'hB0, HT, B, B, B); settle();
    chk("swap.grant", 32'(g), 1);
    chk_flit("x1", fl(8'h91, T), 0, 1);
    step(); req = 0; settle();
    chk("swap.occ", 32'(occ), 2);
    chk_flit("y0", fl(8'hA0, H), 1, 0);
    step(); chk_flit("y1", fl(8'hA1, T), 0, 1);
    step(); chk_flit("z0", fl(8'hB0, HT), 1, 1);
    step(); chk("swap.empty", 32'(occ), 0);
    // malformed head
    ready = 0;
    push(pk(8'hC0, B, T, B, B));
`ifdef PKT2MSG_FORMAT_CHECK_EN
    chk("fmt.occ", 32'(occ), 0);
    chk("fmt.valid", 32'(valid), 0);
    chk("fmt.err", 32'(err), 1);
    step(); chk("fmt.err_sticky", 32'(err), 1);
`else
    chk("fmt.occ", 32'(occ), 1);
    chk("fmt.err", 32'(err), 0);
    chk_flit("fmt.f0", fl(8'hC0, B), 1, 0);
    ready = 1;
    step(); chk_flit("fmt.f1", fl(8'hC1, T), 0, 1);
    ready = 0;
`endif
    // reset mid-stream drops everything
    push(pk(8'hD0, H, B, T, B));
    push(pk(8'hE0, H, T, B, B));
    ready = 1;
    step();
    rst = 1; step(); rst = 0; settle();
    chk("midrst.occ", 32'(occ), 0);
    chk("midrst.valid", 32'(valid), 0);
    chk("midrst.err", 32'(err), 0);
    push(pk(8'hF0, HT, B, B, B));
    chk_flit("postrst", fl(8'hF0, HT), 1, 1);
    $display("%0d/%0d checks passed", pass_cnt, tot);
    $finish;
  end
endmodule
